filter_result_buffer: RTL

Capture buffer placed directly downstream of the `filter` block. It takes each result that `filter` strobes out on `ready_o`, tags the result with a sequence number, and holds it in a first-word-fall-through FIFO until a consumer pops it. It also keeps sticky copies of the filter error flags and a FIFO overflow flag, so software or a downstream stage can detect lost or corrupt results.

---
 rtl/filter_result_buffer.sv | 105 ++++++++++
 1 files changed

// File: rtl/filter_result_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | filter_result_buffer: sequence-tagged FWFT capture FIFO behind `filter`, |
// | with sticky overflow and error flags.              Revision: 1.0         |
// +--------------------------------------------------------------------------+
module filter_result_buffer #(
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       enable_i,
   input  logic [31:0]                inp_i,
   input  logic                       ready_i,
   input  logic [1:0]                 err_i,
   input  logic                       rd_en_i,
   output logic                       rd_valid_o,
   output logic [31:0]                data_o,
   output logic [15:0]                seq_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic [1:0]                 err_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [47:0]      mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [15:0]      seq_q, seq_d;
   logic             enable_dly_q, enable_dly_d;
   logic             overflow_q, overflow_d;
   logic [1:0]       err_q, err_d;

   logic             rise, wr_req, full, pop, wr_en;
   logic [PTR_W-1:0] base_wr, base_rd;
   logic [CNT_W-1:0] base_cnt;
   logic [15:0]      base_seq;

   always_comb begin
      rise   = enable_i & ~enable_dly_q;
      wr_req = ready_i & enable_i;
      full   = (count_q == FULL_COUNT);
      // A rising enable flushes first, so a pop in that cycle has nothing to take.
      pop    = rd_en_i & (count_q != '0) & ~rise;

      base_wr  = rise ? '0 : wr_ptr_q;
      base_rd  = rise ? '0 : rd_ptr_q;
      base_cnt = rise ? '0 : count_q;
      base_seq = rise ? '0 : seq_q;

      wr_en = wr_req & (rise | ~full | pop);

      wr_ptr_d = wr_en ? base_wr + PTR_W'(1) : base_wr;
      rd_ptr_d = pop   ? base_rd + PTR_W'(1) : base_rd;
      case ({wr_en, pop})
         2'b10:   count_d = base_cnt + CNT_W'(1);
         2'b01:   count_d = base_cnt - CNT_W'(1);
         default: count_d = base_cnt;
      endcase

      // Dropped results still consume a sequence number so gaps are visible.
      seq_d        = wr_req ? base_seq + 16'd1 : base_seq;
      overflow_d   = (rise ? 1'b0 : overflow_q) | (wr_req & ~wr_en);
      err_d        = (rise ? 2'b00 : err_q) | (enable_i ? err_i : 2'b00);
      enable_dly_d = enable_i;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         seq_q        <= '0;
         enable_dly_q <= 1'b0;
         overflow_q   <= 1'b0;
         err_q        <= 2'b00;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         seq_q        <= seq_d;
         enable_dly_q <= enable_dly_d;
         overflow_q   <= overflow_d;
         err_q        <= err_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i && wr_en) begin
         mem_q[base_wr] <= {base_seq, inp_i};
      end
   end

   // Storage is not reset, so the head is masked to zero while empty.
   assign rd_valid_o = (count_q != '0);
   assign data_o     = rd_valid_o ? mem_q[rd_ptr_q][31:0]  : 32'd0;
   assign seq_o      = rd_valid_o ? mem_q[rd_ptr_q][47:32] : 16'd0;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;
   assign err_o      = err_q;

endmodule
`default_nettype wire
